// File: rtl/ifq_pkg.sv
// Shared constants and the queue entry layout for the instruction prefetch queue.
package ifq_pkg;

  localparam int                    IFQ_ADDR_W   = 16;
  localparam int                    IFQ_INSTR_W  = 16;
  localparam logic [IFQ_ADDR_W-1:0] IFQ_RESET_PC = '0;
  localparam int                    IFQ_PC_STEP  = 4;

  // One queued fetch: the instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [IFQ_ADDR_W-1:0]  pc;
    logic [IFQ_INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular entry store for the prefetch queue: array, read/write pointers and
// occupancy count. A flush empties the queue and overrides push/pop.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = $bits(ifq_entry_t)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [ENTRY_W-1:0]         wrData,
  output logic [ENTRY_W-1:0]         head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;

  assign head = mem[rdPtr];

  // Pointer and occupancy bookkeeping; flush wins over any push/pop that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-side prefetch buffer: owns the fetch PC, issues one sequential read per
// cycle to a 1-cycle synchronous instruction memory, queues returned
// instructions with their PCs and hands them to decode via valid/ready.
// A branch redirect flushes queued and in-flight fetches.
module instr_prefetch_queue
  import ifq_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = IFQ_ADDR_W,
  parameter int                INSTR_W  = IFQ_INSTR_W,
  parameter int                PC_STEP  = IFQ_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  function automatic logic [ADDR_W-1:0] nextPc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

  logic [ADDR_W-1:0]  fetchPc;
  logic [ADDR_W-1:0]  issuedPc;
  logic               inflight;
  logic               dropNext;
  logic [CNT_W-1:0]   fifoCount;
  logic [ENTRY_W-1:0] head;
  logic [OCC_W-1:0]   occupancy;
  logic               pop;
  logic               push;
  logic [ADDR_W-1:0]  headPc;
  logic [INSTR_W-1:0] headInstr;

  // A pop in a redirect cycle is squashed; the flush discards the head anyway.
  assign pop  = out_valid && out_ready && !redirect;
  assign push = imem_rvalid && !dropNext;

  // Entries held plus the one response still on its way back.
  assign occupancy = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inflight};

  // Issue only while the slot freed by this cycle's pop keeps room for the reply.
  assign imem_req  = !reset && !redirect &&
                     ((occupancy - {{CNT_W{1'b0}}, pop}) < OCC_W'(DEPTH));
  assign imem_addr = fetchPc;

  assign out_valid = (fifoCount != '0);
  assign headPc    = head[ENTRY_W-1 -: ADDR_W];
  assign headInstr = head[INSTR_W-1:0];
  // Empty queue shows zeros so the outputs stay stable and clean out of reset.
  assign out_pc    = out_valid ? headPc    : '0;
  assign out_instr = out_valid ? headInstr : '0;

  ifq_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (redirect),
    .wrData ({issuedPc, imem_rdata}),
    .head   (head),
    .count  (fifoCount)
  );

  // Fetch PC, in-flight tracking and response-drop control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      inflight <= 1'b0;
      dropNext <= 1'b0;
    end else begin
      inflight <= imem_req;
      dropNext <= redirect ? inflight : 1'b0;
      if (redirect)      fetchPc <= redirect_pc;
      else if (imem_req) fetchPc <= nextPc(fetchPc);
    end
  end

  // Remember the address of each issued read so it pairs with its returned data.
  always_ff @(posedge clk) begin
    if (imem_req) issuedPc <= fetchPc;
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a 1-cycle memory returning addr>>2.
module tb_instr_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  int total = 0;
  int bad   = 0;

  instr_prefetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: one-cycle latency, data = address >> 2.
  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= imem_addr >> 2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // The queue must never hold more than DEPTH entries.
  always @(negedge clk) begin
    if (!reset) chk("noOverflow", {31'b0, (dut.fifoCount <= 3'd4)}, 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expHead(input string tag, input logic [15:0] pc, input logic [15:0] instr);
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_pc"}, {16'b0, out_pc}, {16'b0, pc});
    chk({tag, "_ins"}, {16'b0, out_instr}, {16'b0, instr});
  endtask

  task automatic expReq(input string tag, input logic req, input logic [15:0] addr);
    chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) chk({tag, "_addr"}, {16'b0, imem_addr}, {16'b0, addr});
  endtask

  // Pulse reset across a clock edge and release it between edges.
  task automatic doReset(input logic ready);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = ready;
    redirect  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int reqs;
    reset       = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", {16'b0, out_pc}, 32'd0);
    chk("rst_ins", {16'b0, out_instr}, 32'd0);

    // Streaming after reset release
    @(negedge clk);
    reset = 1'b0;
    #1;
    expReq("s0", 1'b1, 16'h0000);
    chk("s0_vld", {31'b0, out_valid}, 32'd0);
    cyc(); #1;
    expReq("s1", 1'b1, 16'h0004);
    chk("s1_vld", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      expHead("stream", 16'(4 * k), 16'(k));
      expReq("streamReq", 1'b1, 16'(4 * k + 8));
    end

    // Backpressure: decode stalled for 10 cycles
    doReset(1'b0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin cyc(); #1; end
      reqs += int'(imem_req);
    end
    chk("bp_reqs", reqs, 32'd4);
    chk("bp_count", {29'b0, dut.fifoCount}, 32'd4);
    chk("bp_reqOff", {31'b0, imem_req}, 32'd0);
    expHead("bp_hold", 16'h0000, 16'h0000);
    cyc();
    out_ready = 1'b1;
    #1;
    expReq("bp_resume", 1'b1, 16'h0010);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin cyc(); #1; end
      expHead("bp_drain", 16'(4 * k), 16'(k));
    end

    // Redirect with 3 queued and 1 in flight
    doReset(1'b0);
    repeat (4) cyc();
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    #1;
    chk("rd_full", {29'b0, dut.fifoCount}, 32'd3);
    chk("rd_req", {31'b0, imem_req}, 32'd0);
    cyc();
    redirect  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rd_gap1", {31'b0, out_valid}, 32'd0);
    expReq("rd_tgt", 1'b1, 16'h0100);
    cyc(); #1;
    chk("rd_gap2", {31'b0, out_valid}, 32'd0);
    expReq("rd_tgt2", 1'b1, 16'h0104);
    cyc(); #1;
    expHead("rd_first", 16'h0100, 16'h0040);
    cyc(); #1;
    expHead("rd_second", 16'h0104, 16'h0041);

    // Redirect while decode is accepting a valid head, target near wrap
    cyc();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    #1;
    expHead("sq_head", 16'h0108, 16'h0042);
    chk("sq_req", {31'b0, imem_req}, 32'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("sq_gap1", {31'b0, out_valid}, 32'd0);
    expReq("wr_a", 1'b1, 16'hFFFC);
    cyc(); #1;
    chk("sq_gap2", {31'b0, out_valid}, 32'd0);
    expReq("wr_b", 1'b1, 16'h0000);
    cyc(); #1;
    expHead("wr_hi", 16'hFFFC, 16'h3FFF);
    cyc(); #1;
    expHead("wr_lo", 16'h0000, 16'h0000);
    cyc(); #1;
    expHead("wr_next", 16'h0004, 16'h0001);

    // Asynchronous reset mid-stream
    #1;
    reset = 1'b1;
    #1;
    chk("ar_vld", {31'b0, out_valid}, 32'd0);
    chk("ar_req", {31'b0, imem_req}, 32'd0);
    chk("ar_pc", {16'b0, out_pc}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expReq("ar_c0", 1'b1, 16'h0000);
    chk("ar_c0_vld", {31'b0, out_valid}, 32'd0);
    cyc(); #1;
    expReq("ar_c1", 1'b1, 16'h0004);
    chk("ar_c1_vld", {31'b0, out_valid}, 32'd0);
    cyc(); #1;
    expHead("ar_first", 16'h0000, 16'h0000);
    cyc(); #1;
    expHead("ar_second", 16'h0004, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
